// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//   Small instruction FIFO between the fetch and decode stages. Each entry
//   holds a {pc, instruction} pair. The queue raises stall_req early enough
//   (SKID free entries) to absorb instructions already in flight from the
//   fetch stage's one-cycle BRAM read. A branch redirect (flush) empties the
//   queue in one cycle. overflow_err latches any instruction that was offered
//   while the queue was full.
//
// Ports
//   clk          : single clock, all state on the rising edge
//   rst_n        : asynchronous active-low reset
//   flush        : discard every queued entry (beats push and pop)
//   in_valid     : fetch presents an instruction this cycle
//   in_pc        : PC of the presented instruction
//   in_inst      : presented instruction word
//   in_ready     : queue can accept an instruction this cycle
//   stall_req    : backpressure to the fetch stage
//   out_valid    : head entry is valid
//   out_pc       : PC of the head entry
//   out_inst     : instruction word of the head entry
//   out_ready    : decode consumes the head entry this cycle
//   count        : number of occupied entries
//   overflow_err : sticky, set when an instruction was offered while full
// ---------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH = 4,
    parameter int SKID  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    output logic                     in_ready,
    output logic                     stall_req,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - SKID);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;

    // Entry storage: {pc, inst}. No reset; validity is tracked by count_q.
    logic [63:0]      mem_q [DEPTH];

    // Readiness is decided from the registered count only, so a pop in the
    // same cycle never lets a full queue accept (no pass-through path).
    assign in_ready     = (count_q != FULL_CNT);
    assign out_valid    = (count_q != '0);
    assign stall_req    = (count_q >= STALL_CNT);
    assign count        = count_q;
    assign overflow_err = overflow_q;
    assign {out_pc, out_inst} = mem_q[rd_ptr_q];

    always_comb begin
        push       = in_valid && in_ready && !flush;
        pop        = out_valid && out_ready && !flush;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (in_valid & ~in_ready & ~flush);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so wrap is implicit.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_pc, in_inst};
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

    localparam int DEPTH = 4;
    localparam int SKID  = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        stall_req;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [2:0]  count;
    logic        overflow_err;

    inst_queue #(.DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_inst      (in_inst),
        .in_ready     (in_ready),
        .stall_req    (stall_req),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_ready    (out_ready),
        .count        (count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [63:0] sb[$];
    int          m_count = 0;
    logic        m_ovf   = 1'b0;
    logic        exp_pop = 1'b0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1300_0013;
    endfunction

    // Drive one cycle of stimulus, advance the model across the edge, then
    // return 2 time units after the edge with inputs idled.
    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        logic m_push;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst_of(pc);
        out_ready = rdy;
        flush     = fl;
        m_push    = v && (m_count != DEPTH) && !fl;
        exp_pop   = (m_count != 0) && rdy && !fl;
        if (m_push) sb.push_back({pc, inst_of(pc)});
        if (v && (m_count == DEPTH) && !fl) m_ovf = 1'b1;
        @(posedge clk);
        if (fl) begin
            sb.delete();
            m_count = 0;
        end else begin
            m_count = m_count + (m_push ? 1 : 0) - (exp_pop ? 1 : 0);
        end
        exp_pop = 1'b0;
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    // Pop side of the scoreboard: mid-cycle, whenever the model expects the
    // head to be consumed, the DUT head must match the oldest pushed entry.
    always @(negedge clk) begin
        if (exp_pop) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pop_underflow: model queue empty at time %0t", $time);
            end else begin
                logic [63:0] exp;
                exp = sb.pop_front();
                if (out_valid !== 1'b1 || {out_pc, out_inst} !== exp) begin
                    bad++;
                    $display("FAIL pop_data: got valid=%b pc=%h inst=%h, want pc=%h inst=%h",
                             out_valid, out_pc, out_inst, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0; flush = 0; in_valid = 0; in_pc = 0; in_inst = 0; out_ready = 0;
        #3;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            stall_req !== 1'b0 || overflow_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: count=%0d ov=%b ir=%b st=%b oe=%b, want 0 0 1 0 0",
                     count, out_valid, in_ready, stall_req, overflow_err);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_fill;
        drive(1, 32'h0, 0, 0);
        total++;
        if (count !== 3'd1 || stall_req !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL first_push: count=%0d st=%b ov=%b, want 1 0 1", count, stall_req, out_valid);
        end
        drive(1, 32'h4, 0, 0);
        drive(1, 32'h8, 0, 0);
        total++;
        if (count !== 3'(m_count) || stall_req !== 1'b1 || in_ready !== 1'b1 || out_pc !== 32'h0) begin
            bad++;
            $display("FAIL fill3: count=%0d st=%b ir=%b pc=%h, want %0d 1 1 00000000",
                     count, stall_req, in_ready, out_pc, m_count);
        end
    endtask

    task automatic test_overflow;
        drive(1, 32'hC, 0, 0);
        total++;
        if (count !== 3'd4 || in_ready !== 1'b0 || overflow_err !== 1'b0) begin
            bad++;
            $display("FAIL full: count=%0d ir=%b oe=%b, want 4 0 0", count, in_ready, overflow_err);
        end
        // Offered while full, with a pop in the same cycle: still refused.
        drive(1, 32'h10, 1, 0);
        total++;
        if (count !== 3'(m_count) || overflow_err !== m_ovf || out_pc !== 32'h4) begin
            bad++;
            $display("FAIL overflow: count=%0d oe=%b pc=%h, want %0d %b 00000004",
                     count, overflow_err, out_pc, m_count, m_ovf);
        end
        for (int i = 0; i < 3; i++) drive(0, 32'h0, 1, 0);
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || overflow_err !== 1'b1 || sb.size() != 0) begin
            bad++;
            $display("FAIL drain: count=%0d ov=%b oe=%b left=%0d, want 0 0 1 0",
                     count, out_valid, overflow_err, sb.size());
        end
    endtask

    task automatic test_stream;
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h200 + 32'(4 * i), 1, 0);
            total++;
            if (count !== 3'd1 || out_pc !== 32'h200 + 32'(4 * i)) begin
                bad++;
                $display("FAIL stream_%0d: count=%0d pc=%h, want 1 %h",
                         i, count, out_pc, 32'h200 + 32'(4 * i));
            end
        end
        drive(0, 32'h0, 1, 0);
        total++;
        if (count !== 3'd0 || sb.size() != 0) begin
            bad++;
            $display("FAIL stream_end: count=%0d left=%0d, want 0 0", count, sb.size());
        end
    endtask

    task automatic test_flush;
        drive(1, 32'h300, 0, 0);
        drive(1, 32'h304, 0, 0);
        drive(1, 32'h308, 0, 0);
        drive(1, 32'h20, 1, 1);
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || overflow_err !== 1'b1) begin
            bad++;
            $display("FAIL flush: count=%0d ov=%b ir=%b oe=%b, want 0 0 1 1",
                     count, out_valid, in_ready, overflow_err);
        end
        drive(1, 32'h40, 0, 0);
        total++;
        if (count !== 3'd1 || out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== inst_of(32'h40)) begin
            bad++;
            $display("FAIL after_flush: count=%0d ov=%b pc=%h, want 1 1 00000040", count, out_valid, out_pc);
        end
        drive(0, 32'h0, 1, 0);
    endtask

    task automatic test_async_reset;
        drive(1, 32'h500, 0, 0);
        drive(1, 32'h504, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            stall_req !== 1'b0 || overflow_err !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: count=%0d ov=%b ir=%b st=%b oe=%b, want 0 0 1 0 0",
                     count, out_valid, in_ready, stall_req, overflow_err);
        end
        sb.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            drive(0, 32'h0, 1, 0);
            total++;
            if (out_valid !== 1'b0 || count !== 3'd0) begin
                bad++;
                $display("FAIL post_reset_%0d: ov=%b count=%0d, want 0 0", i, out_valid, count);
            end
        end
    endtask

    task automatic test_push_pop_empty;
        drive(1, 32'h100, 1, 0);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || count !== 3'd1) begin
            bad++;
            $display("FAIL empty_push_pop: ov=%b pc=%h count=%0d, want 1 00000100 1",
                     out_valid, out_pc, count);
        end
        drive(0, 32'h0, 1, 0);
        total++;
        if (count !== 3'd0 || sb.size() != 0) begin
            bad++;
            $display("FAIL final_drain: count=%0d left=%0d, want 0 0", count, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_stream();
        test_flush();
        test_async_reset();
        test_push_pop_empty();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
